// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad scanner: event word layout, width helper
// and the default row-slot divider for a 50 MHz system clock.
package keypad_pkg;

    localparam int unsigned TICK_DIV_50MHZ = 100000;
    localparam int unsigned EV_CODE_LSB    = 0;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(n)) r = i + 1;
        end
        return r;
    endfunction

    // Event word: release flag sits just above the key code.
    function automatic int unsigned ev_rel_bit(input int unsigned cw);
        return cw;
    endfunction

    function automatic int unsigned ev_width(input int unsigned cw);
        return cw + 1;
    endfunction

endpackage

// File: rtl/keypad_event_fifo.sv
// First-word-fallthrough event queue; the head is visible whenever not empty,
// and a push into a full queue is dropped unless a pop frees a slot that cycle.
module keypad_event_fifo
    import keypad_pkg::*;
#(
    parameter int unsigned WIDTH = 5,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic             drop
);

    localparam int unsigned AW = clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign drop    = push && full && !do_pop;
    // Empty head reads as zero so the outputs are defined before the first push.
    assign dout    = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/keypad_scanner.sv
// Row-multiplexed keypad scanner with frame debounce, single-key press/release
// event generation and a queued valid/ready event interface.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned ROWS       = 4,
    parameter int unsigned COLS       = 4,
    parameter int unsigned TICK_DIV   = TICK_DIV_50MHZ,
    parameter int unsigned DEBOUNCE   = 3,
    parameter int unsigned FIFO_DEPTH = 4,
    localparam int unsigned CW        = clog2(ROWS * COLS)
) (
    input  logic            clock,
    input  logic            resetn,
    input  logic            enable,
    input  logic [COLS-1:0] col_sense,
    output logic [ROWS-1:0] row_drive,
    output logic            key_valid,
    output logic [CW-1:0]   key_code,
    output logic            key_release,
    input  logic            key_ready,
    output logic            multi_key,
    output logic            overflow,
    input  logic            clear_ovf
);

    localparam int unsigned NK      = ROWS * COLS;
    localparam int unsigned TW      = clog2(TICK_DIV);
    localparam int unsigned RW      = clog2(ROWS);
    localparam int unsigned SW      = clog2(DEBOUNCE) + 1;
    localparam int unsigned EW      = ev_width(CW);
    localparam int unsigned REL_BIT = ev_rel_bit(CW);

    localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
    localparam logic [RW-1:0] ROW_LAST   = RW'(ROWS - 1);
    localparam logic [SW-1:0] STABLE_MAX = SW'(DEBOUNCE - 1);

    function automatic int unsigned popcount(input logic [NK-1:0] m);
        int unsigned n;
        n = 0;
        for (int i = 0; i < NK; i++) n += int'(m[i]);
        return n;
    endfunction

    function automatic logic [CW-1:0] first_key(input logic [NK-1:0] m);
        logic [CW-1:0] k;
        k = '0;
        for (int i = 0; i < NK; i++) begin
            if (m[i]) k = CW'(i);
        end
        return k;
    endfunction

    logic [COLS-1:0] col_meta_p0;
    logic [COLS-1:0] col_sync_p1;
    logic [COLS-1:0] cols;
    logic [TW-1:0]   tick_cnt;
    logic [RW-1:0]   row_idx;
    logic [RW-1:0]   row_next;
    logic            tick;
    logic            frame_end;
    logic            accept;
    logic [NK-1:0]   frame_map;
    logic [NK-1:0]   frame_new;
    logic [NK-1:0]   prev_map;
    logic [NK-1:0]   accepted_map;
    logic [SW-1:0]   stable_cnt;
    logic [SW-1:0]   stable_nxt;
    logic            acc_upd_p1;
    logic            was_empty_p1;
    logic            latched;
    logic [CW-1:0]   latched_code;
    int unsigned     acc_cnt;
    logic            press_evt;
    logic            rel_evt;
    logic            fifo_push;
    logic            fifo_pop;
    logic            fifo_empty;
    logic            fifo_full_unused;
    logic            fifo_drop;
    logic [EW-1:0]   push_data;
    logic [EW-1:0]   fifo_dout;

    // Stage p0/p1: two-flop synchroniser, idle level is pulled-up (not pressed).
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            col_meta_p0 <= '1;
            col_sync_p1 <= '1;
        end else begin
            col_meta_p0 <= col_sense;
            col_sync_p1 <= col_meta_p0;
        end
    end

    assign cols      = ~col_sync_p1;
    assign tick      = (tick_cnt == TICK_LAST);
    assign frame_end = tick && (row_idx == ROW_LAST);
    assign row_next  = !tick ? row_idx : ((row_idx == ROW_LAST) ? '0 : row_idx + 1'b1);

    always_comb begin
        frame_new = frame_map;
        frame_new[row_idx * COLS +: COLS] = cols;
    end

    always_comb begin
        stable_nxt = '0;
        if (frame_new == prev_map) begin
            stable_nxt = (stable_cnt == STABLE_MAX) ? stable_cnt : stable_cnt + 1'b1;
        end
    end

    assign accept    = frame_end && (stable_nxt == STABLE_MAX) && (frame_new != accepted_map);
    assign acc_cnt   = popcount(accepted_map);
    assign multi_key = (acc_cnt > 1);

    // Stage p1: event decision one cycle after the accepted map moves.
    assign press_evt = enable && acc_upd_p1 && was_empty_p1 && (acc_cnt == 1) && !latched;
    assign rel_evt   = enable && acc_upd_p1 && (acc_cnt == 0) && latched;
    assign fifo_push = press_evt || rel_evt;
    assign push_data = rel_evt ? {1'b1, latched_code} : {1'b0, first_key(accepted_map)};

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            row_drive    <= '1;
            tick_cnt     <= '0;
            row_idx      <= '0;
            stable_cnt   <= '0;
            frame_map    <= '0;
            prev_map     <= '0;
            accepted_map <= '0;
            acc_upd_p1   <= 1'b0;
            was_empty_p1 <= 1'b0;
            latched      <= 1'b0;
            latched_code <= '0;
        end else if (!enable) begin
            row_drive    <= '1;
            tick_cnt     <= '0;
            row_idx      <= '0;
            stable_cnt   <= '0;
            frame_map    <= '0;
            prev_map     <= '0;
            accepted_map <= '0;
            acc_upd_p1   <= 1'b0;
            was_empty_p1 <= 1'b0;
            latched      <= 1'b0;
            latched_code <= '0;
        end else begin
            row_drive  <= ~(ROWS'(1) << row_next);
            tick_cnt   <= tick ? '0 : tick_cnt + 1'b1;
            row_idx    <= row_next;
            acc_upd_p1 <= accept;
            if (tick) frame_map <= frame_new;
            if (frame_end) begin
                prev_map   <= frame_new;
                stable_cnt <= stable_nxt;
            end
            if (accept) begin
                accepted_map <= frame_new;
                was_empty_p1 <= (acc_cnt == 0);
            end
            if (press_evt) begin
                latched      <= 1'b1;
                latched_code <= first_key(accepted_map);
            end else if (rel_evt) begin
                latched <= 1'b0;
            end
        end
    end

    // Sticky drop flag; a drop in the same cycle as a clear keeps it set.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            overflow <= 1'b0;
        end else if (fifo_drop) begin
            overflow <= 1'b1;
        end else if (clear_ovf) begin
            overflow <= 1'b0;
        end
    end

    assign fifo_pop = key_valid && key_ready;

    keypad_event_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock  (clock),
        .resetn (resetn),
        .push   (fifo_push),
        .din    (push_data),
        .pop    (fifo_pop),
        .dout   (fifo_dout),
        .full   (fifo_full_unused),
        .empty  (fifo_empty),
        .drop   (fifo_drop)
    );

    assign key_valid   = !fifo_empty;
    assign key_release = fifo_dout[REL_BIT];
    assign key_code    = fifo_dout[CW-1:EV_CODE_LSB];

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a behavioural 4x4 key matrix model.
module tb_keypad_scanner;

    logic       clock;
    logic       resetn;
    logic       enable;
    logic [3:0] col_sense;
    logic [3:0] row_drive;
    logic       key_valid;
    logic [3:0] key_code;
    logic       key_release;
    logic       key_ready;
    logic       multi_key;
    logic       overflow;
    logic       clear_ovf;
    logic [15:0] keys;

    int total = 0;
    int bad   = 0;
    int ecount = 0;
    logic [4:0] got_q[$];

    typedef struct {
        int         cyc;
        logic [3:0] drive;
    } row_vec_t;

    typedef struct {
        int         code;
        logic [4:0] exp_press;
        logic [4:0] exp_rel;
    } pair_vec_t;

    keypad_scanner #(
        .ROWS       (4),
        .COLS       (4),
        .TICK_DIV   (10),
        .DEBOUNCE   (3),
        .FIFO_DEPTH (4)
    ) dut (
        .clock       (clock),
        .resetn      (resetn),
        .enable      (enable),
        .col_sense   (col_sense),
        .row_drive   (row_drive),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .key_release (key_release),
        .key_ready   (key_ready),
        .multi_key   (multi_key),
        .overflow    (overflow),
        .clear_ovf   (clear_ovf)
    );

    always #5 clock = ~clock;

    // A pressed key pulls its column low while its row is driven low.
    always_comb begin
        col_sense = '1;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (!row_drive[r] && keys[r*4+c]) col_sense[c] = 1'b0;
            end
        end
    end

    always @(negedge clock) begin
        if (resetn && key_valid && key_ready) got_q.push_back({key_release, key_code});
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            ecount++;
        end
        #1;
    endtask

    task automatic goto(input int n);
        step(n - ecount);
    endtask

    function automatic logic [5:0] qat(input int i);
        if (i < got_q.size()) return {1'b0, got_q[i]};
        return 6'h3f;
    endfunction

    row_vec_t  row_tbl[9];
    pair_vec_t pair_tbl[5];

    initial begin
        bit seen;

        row_tbl[0] = '{1,  4'b1110};
        row_tbl[1] = '{9,  4'b1110};
        row_tbl[2] = '{10, 4'b1101};
        row_tbl[3] = '{19, 4'b1101};
        row_tbl[4] = '{20, 4'b1011};
        row_tbl[5] = '{30, 4'b0111};
        row_tbl[6] = '{39, 4'b0111};
        row_tbl[7] = '{40, 4'b1110};
        row_tbl[8] = '{50, 4'b1101};

        pair_tbl[0] = '{1, 5'h01, 5'h11};
        pair_tbl[1] = '{2, 5'h02, 5'h12};
        pair_tbl[2] = '{3, 5'h03, 5'h13};
        pair_tbl[3] = '{4, 5'h04, 5'h14};
        pair_tbl[4] = '{6, 5'h06, 5'h16};

        clock = 0; resetn = 1; enable = 0; keys = '0; key_ready = 0; clear_ovf = 0;
        #2 resetn = 0;
        #20;
        check("rst_row_drive", row_drive, 4'b1111);
        check("rst_key_valid", key_valid, 0);
        check("rst_key_code", key_code, 0);
        check("rst_key_release", key_release, 0);
        check("rst_multi_key", multi_key, 0);
        check("rst_overflow", overflow, 0);
        @(posedge clock); #1 resetn = 1;
        @(posedge clock); #1 enable = 1;
        ecount = 0;

        // Row scan order and slot length.
        for (int i = 0; i < 9; i++) begin
            goto(row_tbl[i].cyc);
            check($sformatf("row_drive_c%0d", row_tbl[i].cyc), row_drive, row_tbl[i].drive);
        end
        check("scan_key_valid", key_valid, 0);
        check("scan_multi_key", multi_key, 0);

        // Single key row 2 / col 1, press latency then release.
        goto(41); keys[9] = 1'b1;
        goto(160);
        check("press_not_yet", key_valid, 0);
        goto(161);
        check("press_valid", key_valid, 1);
        check("press_code", key_code, 9);
        check("press_type", key_release, 0);
        check("press_multi", multi_key, 0);
        goto(200); keys[9] = 1'b0;
        goto(321);
        check("rel_head_kept", {key_valid, key_release, key_code}, {1'b1, 5'h09});
        key_ready = 1;
        goto(323);
        check("drain_valid_low", key_valid, 0);
        check("drain_count", got_q.size(), 2);
        check("drain_press", qat(0), 6'h09);
        check("drain_release", qat(1), 6'h19);

        // Bounce on col 1, then a clean hold.
        got_q.delete();
        keys[9] = 1'b1;
        for (int t = 0; t < 13; t++) begin
            step(15);
            keys[9] = ~keys[9];
        end
        check("bounce_no_event", got_q.size(), 0);
        check("bounce_valid_low", key_valid, 0);
        keys[9] = 1'b1;
        step(200);
        check("bounce_one_press", got_q.size(), 1);
        check("bounce_press_code", qat(0), 6'h09);
        keys[9] = 1'b0;
        step(200);
        check("bounce_rel_count", got_q.size(), 2);
        check("bounce_rel_code", qat(1), 6'h19);

        // Two keys together: level only, no events.
        got_q.delete();
        keys = 16'h0021;
        step(200);
        check("multi_set", multi_key, 1);
        check("multi_no_event", got_q.size(), 0);
        keys = '0;
        step(200);
        check("multi_clear", multi_key, 0);
        check("multi_rel_no_event", got_q.size(), 0);

        // Five press/release pairs with the consumer stalled.
        got_q.delete();
        key_ready = 0;
        for (int i = 0; i < 5; i++) begin
            keys = 16'(1) << pair_tbl[i].code;
            step(200);
            keys = '0;
            step(200);
        end
        check("ovf_set", overflow, 1);
        check("ovf_head", {key_valid, key_release, key_code}, {1'b1, pair_tbl[0].exp_press});
        clear_ovf = 1; step(1); clear_ovf = 0;
        check("ovf_cleared", overflow, 0);
        key_ready = 1;
        step(8);
        check("ovf_drain_count", got_q.size(), 4);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("ovf_drain_p%0d", i), qat(2*i), {1'b0, pair_tbl[i].exp_press});
            check($sformatf("ovf_drain_r%0d", i), qat(2*i+1), {1'b0, pair_tbl[i].exp_rel});
        end
        check("ovf_drain_valid_low", key_valid, 0);
        check("ovf_stays_clear", overflow, 0);

        // Disable while a key is latched: no release, queued press survives.
        got_q.delete();
        key_ready = 0;
        keys = 16'h0008;
        seen = 0;
        for (int i = 0; i < 400 && !seen; i++) begin
            step(1);
            if (key_valid) seen = 1;
        end
        check("en_press_seen", seen, 1);
        enable = 0;
        step(2);
        check("en_row_idle", row_drive, 4'b1111);
        check("en_multi_low", multi_key, 0);
        keys = '0;
        step(120);
        check("en_fifo_kept", {key_valid, key_release, key_code}, {1'b1, 5'h03});
        enable = 1;
        step(200);
        key_ready = 1;
        step(4);
        check("en_only_press", got_q.size(), 1);
        check("en_press_code", qat(0), 6'h03);
        check("en_valid_low", key_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
